regfile_wb_arbiter: RTL

- Shares the single register-file write port between two writers: the in-order ALU writeback (fixed timing, highest priority) and the long-latency unit (load/multiply, variable timing).
- Buffers long-latency results in a small FIFO and keeps a 32-entry pending-write scoreboard so decode can stall on RAW/WAW hazards.
- Includes a starvation guard that holds the ALU for one cycle so buffered results always drain.
- Sits between the execute/memory stages and the register file; drives the register file's write enable, destination number and data directly.

---
 rtl/regfile_wb_arbiter_if.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter signal bundle: ALU writeback, long-latency result
// handshake, decode hazard query and register-file write port.
interface regfile_wb_arbiter_if;
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        issue_lu;
    logic [4:0]  issue_rd;
    logic [4:0]  src1_num;
    logic [4:0]  src2_num;
    logic [4:0]  dec_rd;
    logic        dec_valid;
    logic        stall;
    logic        hold_alu;
    logic        reg_we;
    logic [4:0]  dstreg_num;
    logic [31:0] dstreg_data;
    logic        proto_err;

    modport slave (
        input  alu_we, alu_rd, alu_data,
        input  lu_valid, lu_rd, lu_data,
        input  issue_lu, issue_rd,
        input  src1_num, src2_num, dec_rd, dec_valid,
        output lu_ready, stall, hold_alu,
        output reg_we, dstreg_num, dstreg_data, proto_err
    );

    modport master (
        output alu_we, alu_rd, alu_data,
        output lu_valid, lu_rd, lu_data,
        output issue_lu, issue_rd,
        output src1_num, src2_num, dec_rd, dec_valid,
        input  lu_ready, stall, hold_alu,
        input  reg_we, dstreg_num, dstreg_data, proto_err
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: ALU first, buffered long-latency
// results drained via a starvation guard, plus a pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input logic                  clk,
    input logic                  rst,
    regfile_wb_arbiter_if.slave  wb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_mem_rd   [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW:0]   r_wp;
    logic [AW:0]   r_rp;
    logic [CW-1:0] r_starve;
    logic          r_hold;
    logic          r_perr;
    logic [31:0]   r_pend;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_sel_alu;
    logic          w_we;
    logic [4:0]    w_num;
    logic [31:0]   w_data;
    logic [4:0]    w_head_rd;
    logic [31:0]   w_head_data;
    logic [31:0]   w_set;
    logic [31:0]   w_clr;

    assign w_empty     = (r_wp == r_rp);
    assign w_full      = (r_wp[AW] != r_rp[AW]) &&
                         (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push      = wb.lu_valid & ~w_full;
    assign w_head_rd   = r_mem_rd[r_rp[AW-1:0]];
    assign w_head_data = r_mem_data[r_rp[AW-1:0]];

    always_comb begin
        w_pop     = 1'b0;
        w_sel_alu = 1'b0;
        w_num     = '0;
        w_data    = '0;
        if (!w_empty && (r_hold || !wb.alu_we)) begin
            w_pop  = 1'b1;
            w_num  = w_head_rd;
            w_data = w_head_data;
        end else if (wb.alu_we) begin
            w_sel_alu = 1'b1;
            w_num     = wb.alu_rd;
            w_data    = wb.alu_data;
        end
        w_we = (w_pop || w_sel_alu) && (w_num != 5'd0);
    end

    // Write port is forced quiet while reset is asserted
    assign wb.reg_we      = rst & w_we;
    assign wb.dstreg_num  = rst ? w_num : 5'd0;
    assign wb.dstreg_data = rst ? w_data : 32'd0;
    assign wb.lu_ready    = ~w_full;
    assign wb.hold_alu    = r_hold;
    assign wb.proto_err   = r_perr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wp[AW-1:0]]   <= wb.lu_rd;
            r_mem_data[r_wp[AW-1:0]] <= wb.lu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + (AW+1)'(1);
            if (w_pop)  r_rp <= r_rp + (AW+1)'(1);
        end
    end

    // Head lost to the ALU too often: block the ALU for one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
            r_hold   <= 1'b0;
        end else begin
            r_hold <= 1'b0;
            if (!w_empty && w_sel_alu) begin
                if (r_starve == CW'(STARVE_LIMIT - 1)) begin
                    r_hold   <= 1'b1;
                    r_starve <= '0;
                end else begin
                    r_starve <= r_starve + CW'(1);
                end
            end else begin
                r_starve <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_perr <= 1'b0;
        else      r_perr <= r_perr | (wb.alu_we & r_hold);
    end

    assign w_clr = w_pop ? (32'd1 << w_head_rd) : 32'd0;
    assign w_set = (wb.issue_lu && wb.issue_rd != 5'd0) ?
                   (32'd1 << wb.issue_rd) : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pend <= '0;
        else      r_pend <= (r_pend & ~w_clr) | w_set;
    end

    assign wb.stall = wb.dec_valid & (r_pend[wb.src1_num] |
                                      r_pend[wb.src2_num] |
                                      r_pend[wb.dec_rd]);
endmodule
